lcd_write_engine: RTL and testbench

Parametrised HD44780-class LCD write engine. It is the successor to the fixed-divide LCD strobe block.
- Latches a byte and RS on a start edge, then drives the bus with programmable setup, enable-width and hold timing.
- Inserts a post-write execution delay, longer for clear/home commands.
- Optionally splits each byte into two nibble transfers for 4-bit panels.
- Sits between the LCD init/text sequencer (host side) and the LCD pins.

---
 rtl/lcd_write_engine.sv | 162 ++++++++++++++++
 tb/tb_lcd_write_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780-class LCD write engine.
// Latches a byte and RS on a rising start edge, then sequences setup,
// enable-high and hold phases followed by an execution wait (longer for
// clear/home commands). Optional 4-bit bus operation is selected by the
// macro LCD_NIBBLE_MODE_EN (two nibble transfers per byte, high nibble first).
module lcd_write_engine #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 16,
    parameter int T_HOLD  = 2,
    parameter int T_WAIT  = 50,
    parameter int T_LONG  = 2000,
    parameter int CNT_W   = 16
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    // Phase lengths below one cycle are clamped to one.
    localparam int unsigned P_SETUP = (T_SETUP < 1) ? 1 : T_SETUP;
    localparam int unsigned P_EN    = (T_EN    < 1) ? 1 : T_EN;
    localparam int unsigned P_HOLD  = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int unsigned P_WAIT  = (T_WAIT  < 1) ? 1 : T_WAIT;
    localparam int unsigned P_LONG  = (T_LONG  < 1) ? 1 : T_LONG;

    localparam logic [CNT_W-1:0] C_SETUP_M1 = CNT_W'(P_SETUP - 1);
    localparam logic [CNT_W-1:0] C_EN_M1    = CNT_W'(P_EN    - 1);
    localparam logic [CNT_W-1:0] C_HOLD_M1  = CNT_W'(P_HOLD  - 1);
    localparam logic [CNT_W-1:0] C_WAIT_M1  = CNT_W'(P_WAIT  - 1);
    localparam logic [CNT_W-1:0] C_LONG_M1  = CNT_W'(P_LONG  - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_start_d;
    logic [7:0]        r_data;
    logic              r_rs;
    logic              r_long;
    logic              r_en;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;
    logic [CNT_W-1:0]  w_wait_m1;
`ifdef LCD_NIBBLE_MODE_EN
    logic              r_lo;
`endif

    assign w_accept  = ~r_start_d & iStart & (r_state == S_IDLE);
    assign w_wait_m1 = r_long ? C_LONG_M1 : C_WAIT_M1;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode: each timed state exits when the counter hits length-1.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: if (r_cnt == C_SETUP_M1) w_next = S_EN_HI;
            S_EN_HI: if (r_cnt == C_EN_M1) w_next = S_HOLD;
            S_HOLD: begin
                if (r_cnt == C_HOLD_M1) begin
`ifdef LCD_NIBBLE_MODE_EN
                    w_next = r_lo ? S_EXEC : S_SETUP;
`else
                    w_next = S_EXEC;
`endif
                end
            end
            S_EXEC:  if (r_cnt == w_wait_m1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Phase counter: cleared on every state change and held at zero in IDLE.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_cnt <= '0;
        else if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
        else r_cnt <= r_cnt + CNT_W'(1);
    end

    // Start-edge history, sampled every cycle regardless of state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_start_d <= 1'b0;
        else         r_start_d <= iStart;
    end

    // Capture byte, RS and wait selection on an accepted start.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_data <= '0;
            r_rs   <= 1'b0;
            r_long <= 1'b0;
        end else if (w_accept) begin
            r_data <= iDATA;
            r_rs   <= iRS;
            r_long <= ~iRS & (iDATA == 8'h01 || iDATA == 8'h02 || iDATA == 8'h03);
        end
    end

`ifdef LCD_NIBBLE_MODE_EN
    // Nibble phase: low nibble selected once the first hold phase completes.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_lo <= 1'b0;
        else if (w_accept) r_lo <= 1'b0;
        else if (r_state == S_HOLD && w_next == S_SETUP) r_lo <= 1'b1;
    end
`endif

    // Registered enable strobe, high exactly while in EN_HI.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_en <= 1'b0;
        else         r_en <= (w_next == S_EN_HI);
    end

    // Handshake flags: busy from accept to completion, done until next accept.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
        end
    end

`ifdef LCD_NIBBLE_MODE_EN
    assign LCD_DATA = r_lo ? {r_data[3:0], 4'h0} : {r_data[7:4], 4'h0};
`else
    assign LCD_DATA = r_data;
`endif
    assign LCD_RS = r_rs;
    assign LCD_RW = 1'b0;
    assign LCD_EN = r_en;
    assign oBusy  = r_busy;
    assign oDone  = r_done;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Testbench for lcd_write_engine: an elapsed-time model checks every output
// each cycle; directed writes pin latency, pulse shape and data literally.
module tb_lcd_write_engine;

    localparam int TS = 2;
    localparam int TE = 16;
    localparam int TH = 2;
    localparam int TW = 50;
    localparam int TL = 2000;
    localparam int PASSLEN = TS + TE + TH;
`ifdef LCD_NIBBLE_MODE_EN
    localparam int NIB = 2;
    localparam int LAT_NORM = 91;
    localparam int LAT_LONG = 2041;
`else
    localparam int NIB = 1;
    localparam int LAT_NORM = 71;
    localparam int LAT_LONG = 2021;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_rs = 1'b0;
    logic       i_start = 1'b0;
    logic       oDone, oBusy, LCD_RW, LCD_EN, LCD_RS;
    logic [7:0] LCD_DATA;

    int tests = 0;
    int fails = 0;
    logic cmp_on = 1'b0;

    lcd_write_engine #(
        .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_WAIT(TW), .T_LONG(TL), .CNT_W(16)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(i_data), .iRS(i_rs), .iStart(i_start),
        .oDone(oDone), .oBusy(oBusy), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: elapsed cycles since accept ----------
    logic       m_prev, m_active, m_rs;
    logic [7:0] m_data;
    int         m_e, m_total;
    logic       exp_busy, exp_done, exp_en;
    logic [7:0] exp_data;

    assign exp_busy = m_active && (m_e < m_total);
    assign exp_done = m_active && (m_e >= m_total);
    assign exp_en   = m_active && (m_e < NIB * PASSLEN) &&
                      ((m_e % PASSLEN) >= TS) && ((m_e % PASSLEN) < TS + TE);
    assign exp_data = (NIB == 1) ? m_data :
                      ((m_e < PASSLEN) ? {m_data[7:4], 4'h0} : {m_data[3:0], 4'h0});

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev <= 1'b0; m_active <= 1'b0; m_rs <= 1'b0;
            m_data <= 8'h00; m_e <= 0; m_total <= 0;
        end else begin
            m_prev <= i_start;
            if (!m_prev && i_start && !exp_busy) begin
                m_active <= 1'b1;
                m_e      <= 0;
                m_data   <= i_data;
                m_rs     <= i_rs;
                m_total  <= NIB * PASSLEN +
                            ((!i_rs && i_data >= 8'h01 && i_data <= 8'h03) ? TL : TW) + 1;
            end else if (m_active && m_e < m_total) begin
                m_e <= m_e + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("busy", 32'(oBusy), 32'(exp_busy));
            chk("done", 32'(oDone), 32'(exp_done));
            chk("en",   32'(LCD_EN), 32'(exp_en));
            chk("rs",   32'(LCD_RS), 32'(m_rs));
            chk("data", 32'(LCD_DATA), 32'(exp_data));
            chk("rw",   32'(LCD_RW), 32'd0);
        end
    end

    // mode 0: plain, 1: second edge 10 cycles in, 2: iStart held 500 cycles
    task automatic do_write(input logic [7:0] d, input logic rs, input int exp_lat,
                            input int mode, input logic [7:0] exp_d1, input logic [7:0] exp_d2);
        int pulses, width, en_first, done_at, busy_fall, extra;
        logic en_prev;
        logic [7:0] d1, d2;
        pulses = 0; width = 0; en_first = -1; done_at = -1; busy_fall = -1;
        extra = 0; en_prev = 1'b0; d1 = 8'h00; d2 = 8'h00;
        @(negedge clk);
        i_data = d; i_rs = rs; i_start = 1'b1;
        @(negedge clk);
        chk("acc_busy", 32'(oBusy), 32'd1);
        chk("acc_done_clr", 32'(oDone), 32'd0);
        if (mode != 2) i_start = 1'b0;
        for (int i = 1; i <= exp_lat + 100 && done_at < 0; i++) begin
            @(negedge clk);
            if (mode == 1 && i == 10) i_start = 1'b1;
            if (mode == 1 && i == 12) i_start = 1'b0;
            if (LCD_EN && !en_prev) begin
                pulses++;
                if (en_first < 0) en_first = i;
                if (pulses == 1) d1 = LCD_DATA; else d2 = LCD_DATA;
                width = 0;
            end
            if (LCD_EN) width++;
            if (!LCD_EN && en_prev) chk("en_width", 32'(width), 32'd16);
            en_prev = LCD_EN;
            if (oDone && done_at < 0) done_at = i;
            if (!oBusy && busy_fall < 0) busy_fall = i;
        end
        if (done_at < 0) begin
            tests++; fails++;
            $display("FAIL done_timeout actual=none required=%0d", exp_lat);
        end
        chk("latency", 32'(done_at), 32'(exp_lat));
        chk("busy_fall", 32'(busy_fall), 32'(exp_lat));
        chk("pulses", 32'(pulses), 32'(NIB));
        chk("en_start", 32'(en_first), 32'd2);
        chk("data_p1", 32'(d1), 32'(exp_d1));
        if (NIB == 2) chk("data_p2", 32'(d2), 32'(exp_d2));
        if (mode == 2) begin
            for (int i = done_at + 1; i <= 500; i++) begin
                @(negedge clk);
                if (LCD_EN && !en_prev) extra++;
                en_prev = LCD_EN;
            end
            chk("held_extra_pulses", 32'(extra), 32'd0);
            chk("held_done", 32'(oDone), 32'd1);
            i_start = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] a5_d1, a5_d2, h41_d1, h41_d2;

    initial begin
`ifdef LCD_NIBBLE_MODE_EN
        a5_d1 = 8'hA0; a5_d2 = 8'h50; h41_d1 = 8'h40; h41_d2 = 8'h10;
`else
        a5_d1 = 8'hA5; a5_d2 = 8'hA5; h41_d1 = 8'h41; h41_d2 = 8'h41;
`endif
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(oDone), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_en", 32'(LCD_EN), 32'd0);
        chk("rst_rs", 32'(LCD_RS), 32'd0);
        chk("rst_data", 32'(LCD_DATA), 32'd0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);

        do_write(8'h41, 1'b1, LAT_NORM, 0, h41_d1, h41_d2);
        do_write(8'h01, 1'b0, LAT_LONG, 0, (NIB == 2) ? 8'h00 : 8'h01, 8'h10);
        do_write(8'h38, 1'b0, LAT_NORM, 0, (NIB == 2) ? 8'h30 : 8'h38, 8'h80);
        do_write(8'h02, 1'b1, LAT_NORM, 1, (NIB == 2) ? 8'h00 : 8'h02, 8'h20);
        do_write(8'h03, 1'b0, LAT_LONG, 0, (NIB == 2) ? 8'h00 : 8'h03, 8'h30);
        do_write(8'h41, 1'b1, LAT_NORM, 2, h41_d1, h41_d2);

        // Reset asserted while EN is high must drop EN and busy asynchronously.
        @(negedge clk);
        i_data = 8'h41; i_rs = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_en", 32'(LCD_EN), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_en", 32'(LCD_EN), 32'd0);
        chk("async_rst_busy", 32'(oBusy), 32'd0);
        chk("async_rst_data", 32'(LCD_DATA), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(8'h41, 1'b1, LAT_NORM, 0, h41_d1, h41_d2);
        do_write(8'hA5, 1'b1, LAT_NORM, 0, a5_d1, a5_d2);

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "timeout");
    end

endmodule
